// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multi-cycle main controller for the single-ALU CPU datapath
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   op, funct         instruction register opcode and function fields
//   aluzero           ALU zero flag (branch decision)
//   memready          memory completes the current access this cycle
//   memreq, memwrite  memory request and write strobe
//   iord              memory address select (0 PC, 1 ALUOut)
//   irwrite, pcwrite  IR and PC load enables
//   pcsrc             PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alusrca, alusrcb  ALU operand selects
//   aluctrl           ALU operation code
//   regdst, memtoreg  register write destination and data selects
//   regwrite          register file write enable
//   illegal           one-cycle pulse on an undecodable instruction
//   state             current state, for debug
//   icount            retired-instruction count, wraps modulo 2^CNTW

module mcycle_ctrl #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            aluzero,
    input  logic            memready,
    output logic            memreq,
    output logic            memwrite,
    output logic            iord,
    output logic            irwrite,
    output logic            pcwrite,
    output logic [1:0]      pcsrc,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [3:0]      aluctrl,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            illegal,
    output logic [3:0]      state,
    output logic [CNTW-1:0] icount
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXE  = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXE   = 4'd9,
        JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t st, st_nx;

    logic memreq_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c;
    logic retire;
    logic rt_ok;
    logic [3:0] rt_alu, i_alu;

    assign state = st;

    // Writes to architectural state are suppressed while reset is held so a
    // reset arriving mid-access cannot leave a half-done store or IR load.
    assign memreq   = memreq_c   & ~rst;
    assign memwrite = memwrite_c & ~rst;
    assign irwrite  = irwrite_c  & ~rst;
    assign pcwrite  = pcwrite_c  & ~rst;
    assign regwrite = regwrite_c & ~rst;

    always_comb begin
        rt_ok  = 1'b1;
        rt_alu = 4'd2;
        unique case (funct)
            6'b100000: rt_alu = 4'd2;
            6'b100010: rt_alu = 4'd6;
            6'b100100: rt_alu = 4'd0;
            6'b100101: rt_alu = 4'd1;
            6'b100110: rt_alu = 4'd4;
            6'b101010: rt_alu = 4'd7;
            default:   rt_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = 4'd2;
        unique case (op)
            OP_ANDI: i_alu = 4'd0;
            OP_ORI:  i_alu = 4'd1;
            OP_SLTI: i_alu = 4'd7;
            default: i_alu = 4'd2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= FETCH;
            icount <= '0;
        end else begin
            st <= st_nx;
            if (retire) begin
                icount <= icount + CNTW'(1);
            end
        end
    end

    always_comb begin
        st_nx      = FETCH;
        retire     = 1'b0;
        memreq_c   = 1'b0;
        memwrite_c = 1'b0;
        iord       = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluctrl    = 4'd2;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_c = 1'b0;
        illegal    = 1'b0;
        unique case (st)
            FETCH: begin
                memreq_c  = 1'b1;
                alusrcb   = 2'b01;
                irwrite_c = memready;
                pcwrite_c = memready;
                st_nx     = memready ? DECODE : FETCH;
            end
            DECODE: begin
                // Speculatively form the branch target while the op is decoded.
                alusrcb = 2'b11;
                unique case (op)
                    OP_LW, OP_SW:                      st_nx = MEMADR;
                    OP_BEQ:                            st_nx = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: st_nx = IEXE;
                    OP_J:                              st_nx = JUMP;
                    OP_RTYPE: begin
                        st_nx   = rt_ok ? RTEXE : FETCH;
                        illegal = ~rt_ok;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                st_nx   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memreq_c = 1'b1;
                iord     = 1'b1;
                st_nx    = memready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                memreq_c   = 1'b1;
                memwrite_c = 1'b1;
                iord       = 1'b1;
                st_nx      = memready ? FETCH : MEMWR;
                retire     = memready;
            end
            RTEXE: begin
                alusrca = 1'b1;
                aluctrl = rt_alu;
                st_nx   = ALUWB;
            end
            IEXE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluctrl = i_alu;
                st_nx   = ALUWB;
            end
            ALUWB: begin
                regdst     = (op == OP_RTYPE);
                regwrite_c = 1'b1;
                retire     = 1'b1;
            end
            BRANCH: begin
                alusrca   = 1'b1;
                aluctrl   = 4'd6;
                pcsrc     = 2'b01;
                pcwrite_c = aluzero;
                retire    = 1'b1;
            end
            JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
                retire    = 1'b1;
            end
            default: st_nx = FETCH;
        endcase
    end

endmodule
